// File: rtl/counter_dir_pkg.sv
// Shared types for the up/down counter direction decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_dir_pkg;

    // Decoder states: first sample, building a streak, locked up, locked down.
    typedef enum logic [1:0] {
        ACQUIRE   = 2'd0,
        SYNC      = 2'd1,
        LOCK_UP   = 2'd2,
        LOCK_DOWN = 2'd3
    } state_t;

    // Classification of one sample relative to the previous one.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_JUMP = 2'd3
    } step_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // True when the decoder currently holds a direction lock.
    function automatic logic is_locked(input state_t s);
        return (s == LOCK_UP) || (s == LOCK_DOWN);
    endfunction

endpackage

// File: rtl/counter_step_classify.sv
// Classifies one counter step as hold/up/down/jump and flags wrap-around.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, caller qualifies with its valid.
module counter_step_classify
    import counter_dir_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_prev,
    input  logic [WIDTH-1:0] i_count,
    output step_t            o_step,
    output logic             o_wrap_up,
    output logic             o_wrap_down
);

    logic [WIDTH-1:0] w_delta;

    // Modular difference; +1 and -1 (all-ones) are the only legal moves.
    assign w_delta = i_count - i_prev;

    // Map the modular difference onto a step class.
    always_comb begin
        o_step = STEP_JUMP;
        if (w_delta == '0) begin
            o_step = STEP_HOLD;
        end else if (w_delta == WIDTH'(1)) begin
            o_step = STEP_UP;
        end else if (w_delta == '1) begin
            o_step = STEP_DOWN;
        end
    end

    // Wrap flags only occur together with an UP or DOWN step (WIDTH >= 2).
    assign o_wrap_up   = (i_prev == '1) && (i_count == '0);
    assign o_wrap_down = (i_prev == '0) && (i_count == '1);

endmodule

// File: rtl/counter_dir_decoder.sv
// Recovers up/down direction from a sampled counter stream, flags holds, wraps and illegal jumps.
// Latency: 1 cycle from an accepted sample to all (registered) outputs.
// Backpressure: none; count_valid qualifies samples, idle cycles freeze state. COUNTER_DIR_DEC_POS_EN adds pos_out.
module counter_dir_decoder
    import counter_dir_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int LOCK_N    = 2,
    parameter int ERR_CNT_W = 8
`ifdef COUNTER_DIR_DEC_POS_EN
    ,
    parameter int POS_W     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 count_valid,
    output logic                 mode_out,
    output logic                 dir_valid,
    output logic                 hold_p,
    output logic                 wrap_up_p,
    output logic                 wrap_down_p,
    output logic                 step_err_p,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef COUNTER_DIR_DEC_POS_EN
    ,
    output logic [POS_W-1:0]     pos_out
`endif
);

    localparam int STREAK_W = $clog2(LOCK_N + 1);

    state_t                r_state,   w_state_nxt;
    logic [WIDTH-1:0]      r_prev,    w_prev_nxt;
    logic [STREAK_W-1:0]   r_streak,  w_streak_nxt;
    logic                  r_sdir,    w_sdir_nxt;
    logic                  r_mode,    w_mode_nxt;
    logic                  r_dv,      w_dv_nxt;
    logic                  r_hold,    w_hold_nxt;
    logic                  r_wup,     w_wup_nxt;
    logic                  r_wdn,     w_wdn_nxt;
    logic                  r_serr,    w_serr_nxt;
    logic [ERR_CNT_W-1:0]  r_err_cnt, w_err_cnt_nxt;
`ifdef COUNTER_DIR_DEC_POS_EN
    logic [POS_W-1:0]      r_pos,     w_pos_nxt;
`endif

    step_t               w_step;
    logic                w_wrap_up;
    logic                w_wrap_down;
    logic                w_dir;
    logic [STREAK_W-1:0] w_len;

    counter_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .i_prev      (r_prev),
        .i_count     (count_in),
        .o_step      (w_step),
        .o_wrap_up   (w_wrap_up),
        .o_wrap_down (w_wrap_down)
    );

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        w_state_nxt   = r_state;
        w_prev_nxt    = r_prev;
        w_streak_nxt  = r_streak;
        w_sdir_nxt    = r_sdir;
        w_mode_nxt    = r_mode;
        w_dv_nxt      = r_dv;
        w_hold_nxt    = 1'b0;
        w_wup_nxt     = 1'b0;
        w_wdn_nxt     = 1'b0;
        w_serr_nxt    = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
`ifdef COUNTER_DIR_DEC_POS_EN
        w_pos_nxt     = r_pos;
`endif
        w_dir         = (w_step == STEP_UP) ? DIR_UP : DIR_DOWN;
        w_len         = '0;

        if (count_valid) begin
            w_prev_nxt = count_in;
            if (r_state == ACQUIRE) begin
                // First sample only seeds the reference value.
                w_state_nxt  = SYNC;
                w_streak_nxt = '0;
            end else begin
                case (w_step)
                    STEP_HOLD: begin
                        w_hold_nxt = 1'b1;
                    end
                    STEP_JUMP: begin
                        w_serr_nxt    = 1'b1;
                        w_err_cnt_nxt = (r_err_cnt == '1) ? r_err_cnt
                                                          : r_err_cnt + ERR_CNT_W'(1);
                        w_state_nxt   = SYNC;
                        w_streak_nxt  = '0;
                        w_dv_nxt      = 1'b0;
                    end
                    default: begin
                        w_wup_nxt = w_wrap_up;
                        w_wdn_nxt = w_wrap_down;
`ifdef COUNTER_DIR_DEC_POS_EN
                        w_pos_nxt = (w_dir == DIR_UP) ? r_pos + POS_W'(1)
                                                      : r_pos - POS_W'(1);
`endif
                        // A locked state only reacts to an opposite step; the
                        // streak direction equals the lock direction while locked.
                        if (!(is_locked(r_state) && (r_sdir == w_dir))) begin
                            if ((r_state == SYNC) && (r_streak != '0) && (r_sdir == w_dir)) begin
                                w_len = r_streak + STREAK_W'(1);
                            end else begin
                                w_len = STREAK_W'(1);
                            end
                            w_streak_nxt = w_len;
                            w_sdir_nxt   = w_dir;
                            if (w_len >= STREAK_W'(LOCK_N)) begin
                                w_state_nxt = (w_dir == DIR_UP) ? LOCK_UP : LOCK_DOWN;
                                w_dv_nxt    = 1'b1;
                                w_mode_nxt  = w_dir;
                            end else begin
                                w_state_nxt = SYNC;
                                w_dv_nxt    = 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ACQUIRE;
            r_prev    <= '0;
            r_streak  <= '0;
            r_sdir    <= DIR_DOWN;
            r_mode    <= DIR_DOWN;
            r_dv      <= 1'b0;
            r_hold    <= 1'b0;
            r_wup     <= 1'b0;
            r_wdn     <= 1'b0;
            r_serr    <= 1'b0;
            r_err_cnt <= '0;
`ifdef COUNTER_DIR_DEC_POS_EN
            r_pos     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_streak  <= w_streak_nxt;
            r_sdir    <= w_sdir_nxt;
            r_mode    <= w_mode_nxt;
            r_dv      <= w_dv_nxt;
            r_hold    <= w_hold_nxt;
            r_wup     <= w_wup_nxt;
            r_wdn     <= w_wdn_nxt;
            r_serr    <= w_serr_nxt;
            r_err_cnt <= w_err_cnt_nxt;
`ifdef COUNTER_DIR_DEC_POS_EN
            r_pos     <= w_pos_nxt;
`endif
        end
    end

    assign mode_out    = r_mode;
    assign dir_valid   = r_dv;
    assign hold_p      = r_hold;
    assign wrap_up_p   = r_wup;
    assign wrap_down_p = r_wdn;
    assign step_err_p  = r_serr;
    assign err_count   = r_err_cnt;
`ifdef COUNTER_DIR_DEC_POS_EN
    assign pos_out     = r_pos;
`endif

endmodule
